// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//   Multi-channel glitch-free clock divider. Every channel turns the system
//   clock into a divided clock with a programmable half-period and its own
//   enable. Each channel also emits a one-cycle tick on every rising edge of
//   its divided clock. A channel never emits a shortened high or low phase:
//   a stop request lets the current period finish, and a divider change only
//   takes effect at the next period boundary.
//
//   Optional feature macro: CLK_DIV_PHASE_EN
//     When defined, a per-channel start delay (phase) is available. A channel
//     started with a non-zero phase waits that many cycles in DELAY before its
//     first rising edge.
//
// Parameters
//   CHANNELS  number of independent divider channels
//   DIV_W     width of each half-period / phase field
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous reset, active high
//   en       in   [CHANNELS]        per-channel run request (level)
//   div      in   [CHANNELS*DIV_W]  half-period in clk cycles, ch i at [i*DIV_W +: DIV_W]
//   phase    in   [CHANNELS*DIV_W]  start delay per channel (CLK_DIV_PHASE_EN only)
//   clk_out  out  [CHANNELS]        divided clocks (registered)
//   tick     out  [CHANNELS]        1-cycle pulse with each clk_out rise (registered)
//   running  out  [CHANNELS]        channel is not idle (registered)
// ---------------------------------------------------------------------------

module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*DIV_W-1:0] div,
`ifdef CLK_DIV_PHASE_EN
    input  logic [CHANNELS*DIV_W-1:0] phase,
`endif
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       running
);

    // Packed view of the flat buses: element i is exactly div[i*DIV_W +: DIV_W].
    logic [CHANNELS-1:0][DIV_W-1:0] div_a;
    assign div_a = div;
`ifdef CLK_DIV_PHASE_EN
    logic [CHANNELS-1:0][DIV_W-1:0] phase_a;
    assign phase_a = phase;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        clk_div_lane #(
            .DIV_W (DIV_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .div     (div_a[g]),
`ifdef CLK_DIV_PHASE_EN
            .phase   (phase_a[g]),
`endif
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .running (running[g])
        );
    end

endmodule

// ---------------------------------------------------------------------------
// clk_div_lane
//   One divider channel. States: IDLE, RUN, STOP (+ DELAY with
//   CLK_DIV_PHASE_EN). All outputs are registered.
//
// Ports
//   clk, rst  system clock / synchronous active-high reset
//   en        run request (level)
//   div       requested half-period (0 treated as 1)
//   phase     start delay in cycles (CLK_DIV_PHASE_EN only)
//   clk_out   divided clock
//   tick      one-cycle pulse coincident with each clk_out rise
//   running   state is not IDLE
// ---------------------------------------------------------------------------

module clk_div_lane #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
`ifdef CLK_DIV_PHASE_EN
    input  logic [DIV_W-1:0] phase,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

`ifdef CLK_DIV_PHASE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STOP  = 2'd2,
        S_DELAY = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STOP  = 2'd2
    } state_e;
`endif

    state_e           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] half_d;
    logic             clk_q;
    logic             tick_q;
    logic             run_q;
    logic             phase_end;
`ifdef CLK_DIV_PHASE_EN
    logic [DIV_W-1:0] dly_q;
`endif

    // Half-period the next period would use; 0 is promoted to 1 (clk/2).
    assign half_d = (div == '0) ? ONE : div;

    // Last cycle of the current high or low phase. cnt_q never exceeds
    // half_q-1, and half_q is never 0, so the counter cannot wrap.
    assign phase_end = (cnt_q == half_q - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= ONE;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
            dly_q   <= '0;
`endif
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                    if (en) begin
`ifdef CLK_DIV_PHASE_EN
                        if (phase != '0) begin
                            // Hold the clock low for 'phase' cycles first.
                            state_q <= S_DELAY;
                            dly_q   <= phase;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            half_q  <= half_d;
                            clk_q   <= 1'b1;
                            tick_q  <= 1'b1;
                            run_q   <= 1'b1;
                        end
`else
                        state_q <= S_RUN;
                        half_q  <= half_d;
                        clk_q   <= 1'b1;
                        tick_q  <= 1'b1;
                        run_q   <= 1'b1;
`endif
                    end
                end

                // RUN and STOP count identically; they only differ in what
                // happens at the low->high boundary. Re-raising en in STOP
                // therefore leaves the waveform untouched.
                S_RUN, S_STOP: begin
                    state_q <= en ? S_RUN : S_STOP;
                    if (phase_end) begin
                        cnt_q <= '0;
                        if (clk_q) begin
                            clk_q <= 1'b0;
                        end else if (en) begin
                            // Period boundary: new rise, pick up a new divider.
                            clk_q  <= 1'b1;
                            tick_q <= 1'b1;
                            half_q <= half_d;
                        end else begin
                            // Stop request seen at the boundary: park low.
                            state_q <= S_IDLE;
                            run_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end

`ifdef CLK_DIV_PHASE_EN
                S_DELAY: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        run_q   <= 1'b0;
                    end else if (cnt_q == dly_q - ONE) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        half_q  <= half_d;
                        clk_q   <= 1'b1;
                        tick_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign running = run_q;

endmodule
